ring_nic: RTL and testbench

- Network interface controller between one processing element (PE) and one ring router node port.
- Processor side: 2-bit register-mapped interface.
- Ring side: drives the router's PE input (pesi/pedi, paced by peri) and consumes its PE output (peso/pedo, paced by pero).
- Buffers packets in both directions in small FIFOs and injects each packet only on the ring phase that matches its virtual-channel bit.

---
 rtl/ring_nic.sv | 136 +++++++++++++
 tb/tb_ring_nic.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_nic.sv
// Ring NIC: register-mapped PE interface with send/receive FIFOs toward a ring router port.
// Optional NIC_STATS_EN adds 16-bit sent/received packet counters to the status words.
module ring_nic #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] d_in,
  output logic [DW-1:0] d_out,
  input  logic          nic_en,
  input  logic          nic_wr_en,
  output logic          net_so,
  output logic [DW-1:0] net_do,
  input  logic          net_ro,
  input  logic          net_si,
  input  logic [DW-1:0] net_di,
  output logic          net_ri,
  input  logic          net_polarity
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] out_mem [DEPTH];
  logic [DW-1:0] in_mem  [DEPTH];
  logic [AW-1:0] out_rd, out_wr, in_rd, in_wr;
  logic [CW-1:0] out_cnt, in_cnt;
  logic          ovf;

  logic out_empty, out_full, in_empty, in_full;
  logic rd_req, wr_req, push, push_ok, ovf_set, send, pop, recv;
  logic [DW-1:0] in_stat, out_stat;

  assign out_empty = (out_cnt == '0);
  assign out_full  = (out_cnt == CW'(DEPTH));
  assign in_empty  = (in_cnt == '0);
  assign in_full   = (in_cnt == CW'(DEPTH));

  assign rd_req  = nic_en && !nic_wr_en;
  assign wr_req  = nic_en && nic_wr_en;
  assign push    = wr_req && (addr == 2'b10);
  assign pop     = rd_req && (addr == 2'b00) && !in_empty;

  // A send frees the head slot at the same edge, so a push to a full FIFO still fits.
  assign net_so  = !out_empty && (out_mem[out_rd][DW-1] == net_polarity);
  assign net_do  = out_empty ? '0 : out_mem[out_rd];
  assign send    = net_so && net_ro;
  assign push_ok = push && (!out_full || send);
  assign ovf_set = push && out_full && !send;

  assign net_ri  = !in_full;
  assign recv    = net_si && net_ri;

`ifdef NIC_STATS_EN
  logic [15:0] sent_cnt, recv_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sent_cnt <= '0;
      recv_cnt <= '0;
    end else begin
      if (send) sent_cnt <= sent_cnt + 16'd1;
      if (recv) recv_cnt <= recv_cnt + 16'd1;
    end
  end
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    in_stat       = '0;
    out_stat      = '0;
    in_stat[0]    = !in_empty;
    in_stat[3:1]  = 3'(in_cnt);
    out_stat[0]   = out_full;
    out_stat[1]   = ovf;
    out_stat[5:2] = 4'(out_cnt);
`ifdef NIC_STATS_EN
    in_stat[31:16]  = recv_cnt;
    out_stat[31:16] = sent_cnt;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_rd  <= '0;
      out_wr  <= '0;
      out_cnt <= '0;
      in_rd   <= '0;
      in_wr   <= '0;
      in_cnt  <= '0;
      ovf     <= 1'b0;
      d_out   <= '0;
    end else begin
      if (rd_req) begin
        unique case (addr)
          2'b00:   d_out <= in_empty ? '0 : in_mem[in_rd];
          2'b01:   d_out <= in_stat;
          2'b11:   d_out <= out_stat;
          default: d_out <= d_out;
        endcase
      end

      // Clear-on-read loses to an overflow arriving in the same cycle.
      if (ovf_set)
        ovf <= 1'b1;
      else if (rd_req && addr == 2'b11)
        ovf <= 1'b0;

      if (push_ok) out_wr <= out_wr + AW'(1);
      if (send)    out_rd <= out_rd + AW'(1);
      unique case ({push_ok, send})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase

      if (recv) in_wr <= in_wr + AW'(1);
      if (pop)  in_rd <= in_rd + AW'(1);
      unique case ({recv, pop})
        2'b10:   in_cnt <= in_cnt + CW'(1);
        2'b01:   in_cnt <= in_cnt - CW'(1);
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; the reset pointers and counts make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) out_mem[out_wr] <= d_in;
    if (recv)    in_mem[in_wr]   <= net_di;
  end

endmodule

// File: tb/tb_ring_nic.sv
// Self-checking bench for ring_nic: directed scenarios plus random traffic against a queue-based model.
// Build with NIC_STATS_EN defined to also check the packet counters.
module tb_ring_nic;

  localparam int DEPTH = 4;
  localparam int DW    = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out;
  logic          nic_en, nic_wr_en;
  logic          net_so, net_ro, net_si, net_ri, net_polarity;
  logic [DW-1:0] net_do, net_di;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] oq[$];
  logic [DW-1:0] iq[$];
  bit            m_ovf;
  int            m_sent, m_recv;
  logic [DW-1:0] m_dout;

  ring_nic #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en),
    .net_so(net_so), .net_do(net_do), .net_ro(net_ro),
    .net_si(net_si), .net_di(net_di), .net_ri(net_ri),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    oq.delete();
    iq.delete();
    m_ovf  = 1'b0;
    m_sent = 0;
    m_recv = 0;
    m_dout = '0;
  endtask

  // One clock cycle: drive inputs, check the combinational ring outputs,
  // advance the model by the cycle's events, then check d_out after the edge.
  task automatic cyc(input bit en, input bit wr, input logic [1:0] a, input logic [DW-1:0] d,
                     input bit ro, input bit si, input logic [DW-1:0] di, input bit pol);
    bit exp_so, exp_ri, snd, rcv;
    logic [DW-1:0] exp_do, istat, ostat;
    nic_en = en; nic_wr_en = wr; addr = a; d_in = d;
    net_ro = ro; net_si = si; net_di = di; net_polarity = pol;
    #1;
    exp_so = (oq.size() > 0) && (oq[0][DW-1] == pol);
    exp_do = (oq.size() > 0) ? oq[0] : '0;
    exp_ri = (iq.size() < DEPTH);
    check("net_so", DW'(net_so), DW'(exp_so));
    check("net_do", net_do, exp_do);
    check("net_ri", DW'(net_ri), DW'(exp_ri));

    snd = exp_so && ro;
    rcv = si && exp_ri;
    istat = '0;
    istat[0]   = (iq.size() > 0);
    istat[3:1] = 3'(iq.size());
    ostat = '0;
    ostat[0]   = (oq.size() == DEPTH);
    ostat[1]   = m_ovf;
    ostat[5:2] = 4'(oq.size());
`ifdef NIC_STATS_EN
    istat[31:16] = 16'(m_recv);
    ostat[31:16] = 16'(m_sent);
`endif
    if (en && !wr) begin
      case (a)
        2'b00: m_dout = (iq.size() > 0) ? iq[0] : '0;
        2'b01: m_dout = istat;
        2'b11: m_dout = ostat;
        default: ;
      endcase
    end
    if (en && !wr && a == 2'b00 && iq.size() > 0) void'(iq.pop_front());
    if (rcv) iq.push_back(di);
    if (snd) void'(oq.pop_front());
    if (en && !wr && a == 2'b11) m_ovf = 1'b0;
    if (en && wr && a == 2'b10) begin
      if (oq.size() < DEPTH) oq.push_back(d);
      else m_ovf = 1'b1;
    end
    if (snd) m_sent++;
    if (rcv) m_recv++;

    @(posedge clk);
    #1;
    check("d_out", d_out, m_dout);
  endtask

  task automatic idle();
    cyc(0, 0, 2'b00, '0, 0, 0, '0, 0);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1, 0, a, '0, 0, 0, '0, 0);
  endtask

  initial begin
    rst = 1'b0;
    addr = '0; d_in = '0; nic_en = 0; nic_wr_en = 0;
    net_ro = 0; net_si = 0; net_di = '0; net_polarity = 0;
    model_clear();
    #2;
    check("reset_net_so", DW'(net_so), '0);
    check("reset_net_ri", DW'(net_ri), DW'(1));
    check("reset_net_do", net_do, '0);
    check("reset_d_out", d_out, '0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Status words after reset.
    rd(2'b01);
    check("reset_in_stat", d_out, '0);
    rd(2'b11);
    check("reset_out_stat", d_out, '0);

    // VC=1 packet waits for polarity 1.
    cyc(1, 1, 2'b10, 64'h8000_0000_0000_00AA, 1, 0, '0, 0);
    cyc(0, 0, 2'b00, '0, 1, 0, '0, 0);
    check("vc_stall_so", DW'(net_so), '0);
    cyc(0, 0, 2'b00, '0, 1, 0, '0, 1);
    cyc(0, 0, 2'b00, '0, 1, 0, '0, 0);
    rd(2'b11);
    check("vc_sent_out_cnt", DW'(d_out[5:2]), '0);

    // Overflow: five pushes with the router stalled.
    for (int i = 0; i < 5; i++)
      cyc(1, 1, 2'b10, DW'(64'h100 + i), 0, 0, '0, 0);
    rd(2'b11);
    check("ovf_status", DW'(d_out[5:0]), DW'(6'b010011));
    rd(2'b11);
    check("ovf_cleared", DW'(d_out[1]), '0);
    for (int i = 0; i < 6; i++)
      cyc(0, 0, 2'b00, '0, 1, 0, '0, 0);
    rd(2'b11);
    check("drained_out_cnt", DW'(d_out[5:2]), '0);

    // Receive five back to back; the fifth is held off.
    for (int i = 1; i <= 5; i++)
      cyc(0, 0, 2'b00, '0, 0, 1, DW'(8'h11 * i), 0);
    check("in_full_ri", DW'(net_ri), '0);
    for (int i = 1; i <= 4; i++) begin
      rd(2'b00);
      check("pop_order", d_out, DW'(8'h11 * i));
    end
    rd(2'b00);
    check("pop_empty", d_out, '0);

    // Pop on the same edge as a receive.
    cyc(0, 0, 2'b00, '0, 0, 1, DW'(8'h11), 0);
    cyc(1, 0, 2'b00, '0, 0, 1, DW'(8'h66), 0);
    check("pop_recv_old_head", d_out, DW'(8'h11));
    rd(2'b01);
    check("pop_recv_cnt", DW'(d_out[3:1]), DW'(1));
    rd(2'b00);
    check("pop_recv_next", d_out, DW'(8'h66));

    // Pop of an empty FIFO together with a receive.
    cyc(1, 0, 2'b00, '0, 0, 1, DW'(8'h77), 0);
    check("pop_empty_recv", d_out, '0);
    rd(2'b00);

    // Push into a full FIFO while the head is sent.
    for (int i = 0; i < 4; i++)
      cyc(1, 1, 2'b10, DW'(64'h200 + i), 0, 0, '0, 0);
    cyc(1, 1, 2'b10, DW'(64'h2AA), 1, 0, '0, 0);
    rd(2'b11);
    check("full_push_send", DW'(d_out[5:0]), DW'(6'b010001));
    for (int i = 0; i < 4; i++)
      cyc(0, 0, 2'b00, '0, 1, 0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [DW-1:0] rdat, rdi;
      rdat = {$urandom, $urandom};
      rdi  = {$urandom, $urandom};
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), rdat,
          1'($urandom_range(0, 2) != 0), 1'($urandom), rdi, 1'($urandom));
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 2'b10, {1'b1, 63'(i)}, 0, 1, DW'(i + 9), 0);
    rst = 1'b0;
    #1;
    model_clear();
    check("midrst_so", DW'(net_so), '0);
    check("midrst_ri", DW'(net_ri), DW'(1));
    check("midrst_do", net_do, '0);
    check("midrst_dout", d_out, '0);
    #3 rst = 1'b1;
    rd(2'b01);
    check("midrst_in_stat", d_out, '0);
    rd(2'b11);
    check("midrst_out_stat", d_out, '0);

`ifdef NIC_STATS_EN
    for (int i = 0; i < 3; i++)
      cyc(1, 1, 2'b10, DW'(i), 1, 0, '0, 0);
    for (int i = 0; i < 2; i++)
      cyc(0, 0, 2'b00, '0, 1, 1, DW'(i), 0);
    rd(2'b11);
    check("stats_sent", DW'(d_out[31:16]), DW'(3));
    rd(2'b01);
    check("stats_recv", DW'(d_out[31:16]), DW'(2));
`endif

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
